// File: rtl/regfile_wb_arbiter.sv
// Write-back controller: round-robin shares the register file's single write port among
// the ALU, load and mul/div producers, and tracks pending destinations for decode.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              req_valid,
  input  logic [3*ADDR_WIDTH-1:0] req_addr,
  input  logic [3*DATA_WIDTH-1:0] req_data,
  output logic [2:0]              req_ready,
  input  logic                    reserve_valid,
  input  logic [ADDR_WIDTH-1:0]   reserve_addr,
  input  logic [ADDR_WIDTH-1:0]   rs_addr,
  input  logic [ADDR_WIDTH-1:0]   rt_addr,
  output logic                    rs_busy,
  output logic                    rt_busy,
  output logic                    reg_write,
  output logic [ADDR_WIDTH-1:0]   write_register,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic [(1<<ADDR_WIDTH)-1:0] pending,
  output logic                    wb_error
);

  localparam int NREG = 1 << ADDR_WIDTH;

  // Handshake: a producer transfers on a rising edge where req_valid[i] & req_ready[i];
  // it holds addr/data stable until then and may drop valid (abandoning the request).
  // req_ready is combinational, one-hot at most, and never depends on a valid bit that is low.

  logic [1:0]            last_q;
  logic [1:0]            p0, p1, p2;
  logic [1:0]            grant_idx;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  wr_en_q;
  logic [NREG-1:0]       pending_q;
  logic [NREG-1:0]       set_vec;
  logic [NREG-1:0]       clr_vec;
  logic [NREG-1:0]       pending_nxt;
  logic                  set_req;
  logic                  res_conflict;
  logic                  clr_unreserved;

  // Search order starts just after the last winner.
  always_comb begin
    p0 = 2'd0;
    p1 = 2'd1;
    p2 = 2'd2;
    case (last_q)
      2'd0: begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1: begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    if (req_valid[p0]) begin
      grant_any = 1'b1;
      grant_idx = p0;
    end else if (req_valid[p1]) begin
      grant_any = 1'b1;
      grant_idx = p1;
    end else if (req_valid[p2]) begin
      grant_any = 1'b1;
      grant_idx = p2;
    end
    if (rst) begin
      grant_any = 1'b0;
    end
    req_ready = grant_any ? (3'b001 << grant_idx) : 3'b000;
  end

  always_comb begin
    sel_addr = req_addr[ADDR_WIDTH-1:0];
    sel_data = req_data[DATA_WIDTH-1:0];
    case (grant_idx)
      2'd1: begin
        sel_addr = req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
        sel_data = req_data[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      2'd2: begin
        sel_addr = req_addr[3*ADDR_WIDTH-1:2*ADDR_WIDTH];
        sel_data = req_data[3*DATA_WIDTH-1:2*DATA_WIDTH];
      end
      default: begin
        sel_addr = req_addr[ADDR_WIDTH-1:0];
        sel_data = req_data[DATA_WIDTH-1:0];
      end
    endcase
  end

  // Scoreboard: a reserve on the same edge as the clearing write wins, since it
  // belongs to a newer producer of that register.
  always_comb begin
    set_req = reserve_valid && (reserve_addr != '0);
    set_vec = '0;
    clr_vec = '0;
    if (set_req) begin
      set_vec[reserve_addr] = 1'b1;
    end
    if (wr_en_q) begin
      clr_vec[write_register] = 1'b1;
    end
    pending_nxt    = (pending_q & ~clr_vec) | set_vec;
    pending_nxt[0] = 1'b0;
    res_conflict   = set_req && pending_q[reserve_addr] &&
                     !(wr_en_q && (write_register == reserve_addr));
    clr_unreserved = wr_en_q && !pending_q[write_register];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q         <= 2'd2;
      wr_en_q        <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
      pending_q      <= '0;
      wb_error       <= 1'b0;
    end else begin
      if (grant_any) begin
        last_q <= grant_idx;
      end
      wr_en_q <= grant_any && (sel_addr != '0);
      if (grant_any && (sel_addr != '0)) begin
        write_register <= sel_addr;
        write_data     <= sel_data;
      end
      pending_q <= pending_nxt;
      if (res_conflict || clr_unreserved) begin
        wb_error <= 1'b1;
      end
    end
  end

  // Masking with rst drops a write already in flight when reset arrives mid-operation.
  assign reg_write = wr_en_q & ~rst;
  assign pending   = pending_q;
  assign rs_busy   = pending_q[rs_addr];
  assign rt_busy   = pending_q[rt_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a random phase, with a
// reference arbiter that queues expected register-file writes.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  v;
  logic [4:0]  a [3];
  logic [31:0] d [3];
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        reserve_valid;
  logic [4:0]  reserve_addr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [31:0] pending;
  logic        wb_error;

  int total = 0;
  int bad   = 0;

  logic [36:0] exp_q[$];
  int          m_last = 2;
  logic        wr_now = 1'b0;
  logic [2:0]  gnt_seen = 3'b000;
  logic [2:0]  rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(v), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
    .pending(pending), .wb_error(wb_error)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Reference arbiter + write scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [36:0] e;
    int          mg;
    int          idx;
    logic        found;
    gnt_seen = req_ready;
    if (rst) begin
      check("rst_ready", req_ready, 0);
      check("rst_wr", reg_write, 0);
      m_last = 2;
      wr_now = 1'b0;
      exp_q.delete();
    end else begin
      check("wr_en", reg_write, wr_now);
      if (reg_write && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_pair", {write_register, write_data}, e);
      end
      found = 1'b0;
      mg = 0;
      for (int k = 1; k <= 3; k++) begin
        idx = (m_last + k) % 3;
        if (!found && v[idx]) begin
          found = 1'b1;
          mg = idx;
        end
      end
      check("grant", req_ready, found ? (64'd1 << mg) : 64'd0);
      wr_now = 1'b0;
      if (found) begin
        m_last = mg;
        if (a[mg] != 5'd0) begin
          exp_q.push_back({a[mg], d[mg]});
          wr_now = 1'b1;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    v = 3'b111;
    a[0] = 5'd3;  a[1] = 5'd4;  a[2] = 5'd5;
    d[0] = 32'hA; d[1] = 32'hB; d[2] = 32'hC;
    reserve_valid = 1'b0;
    reserve_addr = 5'd0;
    rs_addr = 5'd0;
    rt_addr = 5'd0;

    // reset with all producers requesting
    @(negedge clk);
    check("rst_grant", req_ready, 3'b000);
    check("rst_pending", pending, 0);
    check("rst_err", wb_error, 0);
    tick();
    tick();
    rst = 1'b0;

    // round robin, writes to 3/4/5 are unreserved
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_grant", req_ready, rr_exp[k]);
      tick();
    end
    v = 3'b000;
    tick();
    @(negedge clk);
    check("rr_err_unres", wb_error, 1);
    do_reset();

    // scoreboard reserve / clear through the load port
    reserve_valid = 1'b1;
    reserve_addr = 5'd7;
    rs_addr = 5'd7;
    rt_addr = 5'd0;
    @(negedge clk);
    check("sb_busy_pre", rs_busy, 0);
    tick();
    reserve_valid = 1'b0;
    v = 3'b010;
    a[1] = 5'd7;
    d[1] = 32'h1234;
    @(negedge clk);
    check("sb_busy_set", rs_busy, 1);
    check("sb_pend_set", pending, 32'h80);
    check("sb_rt_zero", rt_busy, 0);
    check("sb_load_grant", req_ready, 3'b010);
    tick();
    v = 3'b000;
    @(negedge clk);
    check("sb_wr", reg_write, 1);
    check("sb_busy_wr", rs_busy, 1);
    tick();
    @(negedge clk);
    check("sb_busy_clr", rs_busy, 0);
    check("sb_pend_clr", pending, 0);
    check("sb_err", wb_error, 0);

    // same-edge reserve and clear of 9
    tick();
    reserve_valid = 1'b1;
    reserve_addr = 5'd9;
    tick();
    reserve_valid = 1'b0;
    v = 3'b001;
    a[0] = 5'd9;
    d[0] = 32'h99;
    tick();
    v = 3'b000;
    reserve_valid = 1'b1;
    reserve_addr = 5'd9;
    @(negedge clk);
    check("se_wr", reg_write, 1);
    tick();
    reserve_valid = 1'b0;
    @(negedge clk);
    check("se_pend", pending, 32'h200);
    check("se_err", wb_error, 0);
    tick();
    v = 3'b001;
    d[0] = 32'h98;
    tick();
    v = 3'b000;
    tick();
    @(negedge clk);
    check("se_pend_clr", pending, 0);
    check("se_err2", wb_error, 0);

    // reserve of index 0 is ignored
    tick();
    reserve_valid = 1'b1;
    reserve_addr = 5'd0;
    tick();
    reserve_valid = 1'b0;
    @(negedge clk);
    check("res_zero", pending, 0);

    // addr 0 write is consumed, no register-file write
    tick();
    v = 3'b001;
    a[0] = 5'd0;
    d[0] = 32'h55;
    @(negedge clk);
    check("a0_grant", req_ready, 3'b001);
    tick();
    v = 3'b000;
    @(negedge clk);
    check("a0_nowr", reg_write, 0);
    check("a0_err", wb_error, 0);

    // double reserve is a sticky error
    tick();
    reserve_valid = 1'b1;
    reserve_addr = 5'd6;
    tick();
    tick();
    reserve_valid = 1'b0;
    @(negedge clk);
    check("dbl_res_err", wb_error, 1);
    tick();
    tick();
    @(negedge clk);
    check("err_sticky", wb_error, 1);
    do_reset();
    @(negedge clk);
    check("err_rst", wb_error, 0);
    check("err_rst_pend", pending, 0);

    // write to unreserved 8
    tick();
    v = 3'b001;
    a[0] = 5'd8;
    d[0] = 32'h88;
    tick();
    v = 3'b000;
    tick();
    @(negedge clk);
    check("unres_err", wb_error, 1);
    do_reset();

    // reset between accept and write
    reserve_valid = 1'b1;
    reserve_addr = 5'd10;
    tick();
    reserve_valid = 1'b0;
    v = 3'b001;
    a[0] = 5'd10;
    d[0] = 32'hAA;
    tick();
    v = 3'b000;
    rst = 1'b1;
    @(negedge clk);
    check("mid_nowr", reg_write, 0);
    tick();
    rst = 1'b0;
    v = 3'b111;
    a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
    @(negedge clk);
    check("mid_pend", pending, 0);
    check("mid_grant", req_ready, 3'b001);
    tick();
    v = 3'b000;
    do_reset();

    // random traffic, checked by the reference arbiter
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!v[i] || gnt_seen[i]) begin
          v[i] = 1'($urandom_range(0, 1));
          a[i] = 5'($urandom_range(0, 31));
          d[i] = $urandom;
        end
      end
      reserve_valid = 1'($urandom_range(0, 1));
      reserve_addr = 5'($urandom_range(0, 31));
      rs_addr = 5'($urandom_range(0, 31));
      tick();
    end
    v = 3'b000;
    reserve_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("drain_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back controller for the 32x32 register file: it shares the file's single write port among three producers (ALU, load unit, multiply/divide unit) with round-robin arbitration, and keeps a pending-write scoreboard for the decode stage. It sits between the execute/memory producers and the register file's `reg_write`/`write_register`/`write_data` inputs. It also answers operand-busy queries for the two read ports.

## Interface

- `DATA_WIDTH`, 32, write data width
- `ADDR_WIDTH`, 5, register index width (32 registers, index 0 hard-wired zero)
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  3  per-producer write request (bit 0 ALU, 1 load, 2 mul/div)
- `req_addr`  in  3*ADDR_WIDTH  destination per producer, producer i at bits [5i+4:5i]
- `req_data`  in  3*DATA_WIDTH  write data per producer, producer i at bits [32i+31:32i]
- `req_ready`  out  3  one-hot grant, combinational; transfer when valid & ready
- `reserve_valid`  in  1  decode marks a destination as pending
- `reserve_addr`  in  ADDR_WIDTH  destination being reserved
- `rs_addr`, `rt_addr`  in  ADDR_WIDTH each  decode operand indices
- `rs_busy`, `rt_busy`  out  1 each  operand has a pending write (combinational)
- `reg_write`  out  1  registered write enable to the register file
- `write_register`  out  ADDR_WIDTH  registered write index
- `write_data`  out  DATA_WIDTH  registered write data
- `pending`  out  32  scoreboard bitmap, bit 0 always 0
- `wb_error`  out  1  sticky protocol-violation flag

## Operation

- Arbiter: round-robin over the three producers. `last` pointer; search order is last+1, last+2, last (mod 3). At most one `req_ready` bit is high, and only for a producer whose `req_valid` is high. `last` updates to the granted index only on a grant.
- Producers hold `req_valid`/`req_addr`/`req_data` stable until accepted. Deasserting valid before acceptance is legal; that request is dropped.
- On accept with addr != 0, the next cycle drives `reg_write`=1, `write_register`=addr, `write_data`=data. With no accept, or an accept with addr 0, the next cycle drives `reg_write`=0. Address and data outputs hold their previous values.
- Addr-0 requests are always granted normally. They are consumed and produce no write.
- Scoreboard set: `reserve_valid` with `reserve_addr` != 0 sets `pending[reserve_addr]` at the edge.
- Scoreboard clear: the edge on which `reg_write`=1 clears `pending[write_register]`. This is the same edge the register file captures the data.
- Simultaneous set and clear of the same index: set wins, so the bit stays 1 (a new producer has been issued).
- `rs_busy` = `pending[rs_addr]` and `rt_busy` = `pending[rt_addr]`. Index 0 is never busy.
- `wb_error` is set, and held until `rst`, on either violation:
  - reserve of an index already pending and not being cleared on that edge;
  - `reg_write`=1 to an index whose pending bit is 0.
- Violations do not alter the arbitration or write behaviour.

## Timing

- Reset values: `reg_write`=0, `write_register`=0, `write_data`=0, `pending`=0, `wb_error`=0, `last`=2 (so ALU wins first).
- Latency: request accept at edge N drives the register-file write in cycle N+1. Data is readable from the register file from cycle N+2.
- The `rs_busy` of a just-reserved index is 1 in the cycle after the reserve edge. It falls in the cycle after the `reg_write` edge.
- Throughput: one write per cycle. A producer waits at most 2 cycles of others' grants.
- `rst` asserted mid-operation: at that edge all state returns to reset values. Any in-flight accepted request is discarded (no `reg_write` next cycle). `req_ready` is 0 while `rst` is high.

## Test plan

- Reset: assert `rst` with all three valid -> `req_ready`=000, `reg_write`=0, `pending`=0. After release, the first grant is `req_ready`=001.
- Round-robin: hold all three valid (addrs 3/4/5, data 0xA/0xB/0xC) for 6 cycles -> grants 001,010,100,001,010,100. Writes appear one cycle later: (3,0xA),(4,0xB),(5,0xC),...
- Scoreboard: reserve 7, then load writes 7 with 0x1234 -> `rs_busy` (rs_addr=7) is 1 from the cycle after the reserve until the cycle after `reg_write`. Then 0, with `pending`=0.
- Same-edge set/clear: reserve 9 on the edge where `reg_write`=1 to 9 -> `pending[9]` stays 1 and `wb_error` stays 0.
- Addr 0 and errors:
  - ALU request to addr 0 -> `req_ready`=001, next cycle `reg_write`=0;
  - reserve 6 twice without a write -> `wb_error`=1 and sticky until `rst`;
  - write to unreserved 8 -> `wb_error`=1.
- Mid-operation reset: accept a request to 10, assert `rst` on the following edge -> no write to 10, `pending`=0, next grant 001.
